// File: rtl/soc_system_onchip_arb_pkg.sv
// soc_system_onchip_arb_pkg: shared types, defaults and round-robin pick for the on-chip memory arbiter
package soc_system_onchip_arb_pkg;
   typedef enum logic {ST_CLEAR, ST_ARB} state_t;
   localparam int ARB_ADDR_W = 6;
   localparam int ARB_DATA_W = 128;
   localparam int MAX_REQ = 4;
   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } pick_t;
   // Walks the candidates from farthest to nearest so the nearest active one, starting at ptr, is assigned last.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] active, input logic [1:0] ptr, input int n);
      pick_t      p;
      logic [1:0] j;
      p = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         j = 2'((int'(ptr) + k) % n);
         if (k < n && active[j]) begin
            p.valid = 1'b1;
            p.idx   = j;
         end
      end
      return p;
   endfunction
endpackage

// File: rtl/soc_system_onchip_memory_arbiter_rr.sv
// soc_system_rr_arbiter: circular priority pick with a pointer that advances past each accepted winner
module soc_system_rr_arbiter
   import soc_system_onchip_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] active,
   input  logic               advance,
   output logic               grant_valid,
   output logic [1:0]         grant_idx
);
   logic [1:0]         rr_ptr;
   logic [MAX_REQ-1:0] act_ext;
   pick_t              pick;
   // Widen the request vector to the package width and pick the winner.
   always_comb begin
      act_ext = '0;
      act_ext[NUM_REQ-1:0] = active;
      pick = rr_pick(act_ext, rr_ptr, NUM_REQ);
   end
   assign grant_valid = pick.valid;
   assign grant_idx   = pick.idx;
   // Pointer moves to the requester after the winner only when the transfer is actually accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rr_ptr <= '0;
      else if (advance) rr_ptr <= (pick.idx == 2'(NUM_REQ - 1)) ? 2'd0 : pick.idx + 2'd1;
   end
endmodule

// File: rtl/soc_system_onchip_memory_arbiter.sv
// soc_system_onchip_memory_arbiter: round-robin sharing of the RAM s1 port with a zero-fill clear sequencer
module soc_system_onchip_memory_arbiter
   import soc_system_onchip_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = ARB_ADDR_W,
   parameter int DATA_W         = ARB_DATA_W,
   parameter int CLEAR_ON_RESET = 1,
   localparam int BE_W          = DATA_W / 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   input  logic [NUM_REQ-1:0]        req_read,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
   input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
   output logic [NUM_REQ-1:0]        req_waitrequest,
   output logic [DATA_W-1:0]         req_readdata,
   output logic [NUM_REQ-1:0]        req_readdatavalid,
   input  logic                      clear_start,
   output logic                      clear_busy,
   output logic [ADDR_W-1:0]         mem_address,
   output logic                      mem_chipselect,
   output logic                      mem_write,
   output logic [DATA_W-1:0]         mem_writedata,
   output logic [BE_W-1:0]           mem_byteenable,
   output logic                      mem_clken,
   input  logic [DATA_W-1:0]         mem_readdata
);
   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_addr;
   logic                rd_pend;
   logic [1:0]          rd_id;
   logic                grant_valid, accept, win_rd, win_wr;
   logic [1:0]          widx;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wd;
   logic [BE_W-1:0]     win_be;

   assign accept       = state == ST_ARB && !clear_start && grant_valid;
   assign mem_clken    = 1'b1;
   assign req_readdata = mem_readdata;

   soc_system_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk         (clk),
      .reset_n     (reset_n),
      .active      (req_read | req_write),
      .advance     (accept),
      .grant_valid (grant_valid),
      .grant_idx   (widx)
   );

   // Select the winning requester's command fields.
   always_comb begin
      win_rd   = 1'b0;
      win_wr   = 1'b0;
      win_addr = '0;
      win_wd   = '0;
      win_be   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (widx == 2'(i)) begin
            win_rd   = req_read[i];
            win_wr   = req_write[i];
            win_addr = req_address[i*ADDR_W +: ADDR_W];
            win_wd   = req_writedata[i*DATA_W +: DATA_W];
            win_be   = req_byteenable[i*BE_W +: BE_W];
         end
      end
   end

   // Next state plus the memory mux: the clear sequencer overrides the granted requester.
   always_comb begin
      state_nxt      = state;
      mem_address    = win_addr;
      mem_writedata  = win_wd;
      mem_byteenable = win_be;
      mem_chipselect = accept;
      mem_write      = accept && win_wr;
      if (state == ST_CLEAR) begin
         mem_address    = clr_addr;
         mem_writedata  = '0;
         mem_byteenable = '1;
         mem_chipselect = 1'b1;
         mem_write      = 1'b1;
         state_nxt      = (clr_addr == '1) ? ST_ARB : ST_CLEAR;
      end else if (clear_start) begin
         state_nxt = ST_CLEAR;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         req_waitrequest[i]   = !(accept && widx == 2'(i));
         req_readdatavalid[i] = rd_pend && rd_id == 2'(i);
      end
   end

   // State, clear address, busy flag and the one-deep read-return tag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
         clear_busy <= CLEAR_ON_RESET != 0;
         clr_addr   <= '0;
         rd_pend    <= 1'b0;
         rd_id      <= '0;
      end else begin
         state      <= state_nxt;
         clear_busy <= state_nxt == ST_CLEAR;
         clr_addr   <= (state == ST_CLEAR) ? clr_addr + 1'b1 : '0;
         rd_pend    <= accept && win_rd && !win_wr;
         rd_id      <= widx;
      end
   end

   // A requester asserting read and write together is a protocol error; the write wins.
   a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset_n) !(accept && win_rd && win_wr));
endmodule

// File: tb/tb_soc_system_onchip_memory_arbiter.sv
// tb_soc_system_onchip_memory_arbiter: cycle-level model and read scoreboard around the arbiter and a RAM model
module tb_soc_system_onchip_memory_arbiter;
   localparam int N = 2, AW = 6, DW = 128, BW = 16, DEPTH = 64;

   logic              clk = 1'b0, reset_n = 1'b0;
   logic [N*AW-1:0]   req_address;
   logic [N-1:0]      req_read, req_write, req_waitrequest, req_readdatavalid;
   logic [N*DW-1:0]   req_writedata;
   logic [N*BW-1:0]   req_byteenable;
   logic [DW-1:0]     req_readdata, mem_writedata, mem_readdata;
   logic              clear_start, clear_busy, mem_chipselect, mem_write, mem_clken;
   logic [AW-1:0]     mem_address;
   logic [BW-1:0]     mem_byteenable;

   always #5 clk = ~clk;

   soc_system_onchip_memory_arbiter dut (
      .clk(clk), .reset_n(reset_n), .req_address(req_address), .req_read(req_read),
      .req_write(req_write), .req_writedata(req_writedata), .req_byteenable(req_byteenable),
      .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
      .req_readdatavalid(req_readdatavalid), .clear_start(clear_start), .clear_busy(clear_busy),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // RAM with registered read: filled with a nonzero pattern first so the clear is visible.
   logic [DW-1:0] ram [DEPTH];
   logic          ram_init = 1'b0;
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= {4{32'hA5A5_0000 | i}};
         ram_init <= 1'b1;
      end else if (mem_chipselect && mem_write) begin
         for (int b = 0; b < BW; b++)
            if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end
      mem_readdata <= ram[mem_address];
   end

   int checks = 0, errors = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] data;
   } rd_t;
   rd_t           sb[$];
   logic [DW-1:0] model [DEPTH];
   int            clr_cnt = DEPTH, m_ptr = 0;
   logic [N-1:0]  acc = '0;

   // Per-cycle model: predicts grants, clear writes and read returns from what the bench drives.
   always @(negedge clk) begin : monitor
      rd_t           e;
      int            win, j;
      logic [N-1:0]  exp_wait;
      logic [AW-1:0] a;
      acc = '0;
      if (!reset_n) begin
         check("rst_wait", req_waitrequest, 2'b11);
         check("rst_rdv", req_readdatavalid, 2'b00);
         check("rst_busy", clear_busy, 1);
         clr_cnt = DEPTH;
         m_ptr = 0;
         sb.delete();
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end else begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rdv", req_readdatavalid, 2'b01 << e.id);
            check("rdata", req_readdata, e.data);
         end else check("rdv_idle", req_readdatavalid, 2'b00);
         if (clr_cnt > 0) begin
            check("clr_busy", clear_busy, 1);
            check("clr_wait", req_waitrequest, 2'b11);
            check("clr_addr", mem_address, DW'(DEPTH - clr_cnt));
            check("clr_ctl", {mem_chipselect, mem_write, mem_byteenable}, {2'b11, 16'hFFFF});
            check("clr_wd", mem_writedata, '0);
            clr_cnt--;
         end else begin
            check("busy", clear_busy, 0);
            if (clear_start) begin
               check("cs_wait", req_waitrequest, 2'b11);
               check("cs_sel", mem_chipselect, 0);
               clr_cnt = DEPTH;
               for (int i = 0; i < DEPTH; i++) model[i] = '0;
            end else begin
               win = -1;
               for (int k = N - 1; k >= 0; k--) begin
                  j = (m_ptr + k) % N;
                  if (req_read[j] || req_write[j]) win = j;
               end
               exp_wait = 2'b11;
               if (win >= 0) exp_wait[win] = 1'b0;
               check("wait", req_waitrequest, exp_wait);
               check("sel", mem_chipselect, win >= 0);
               if (win >= 0) begin
                  a = req_address[win*AW +: AW];
                  check("addr", mem_address, a);
                  check("we", mem_write, req_write[win]);
                  acc[win] = 1'b1;
                  m_ptr = (win + 1) % N;
                  if (req_write[win]) begin
                     for (int b = 0; b < BW; b++)
                        if (req_byteenable[win*BW + b]) model[a][b*8 +: 8] = req_writedata[win*DW + b*8 +: 8];
                  end else begin
                     e.id = 2'(win);
                     e.data = model[a];
                     sb.push_back(e);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic rd, input logic wr, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd, input logic [BW-1:0] be);
      req_read[i] = rd;
      req_write[i] = wr;
      req_address[i*AW +: AW] = ad;
      req_writedata[i*DW +: DW] = wd;
      req_byteenable[i*BW +: BW] = be;
   endtask

   task automatic hold(input int i, input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!acc[i] && n < 200);
      check(tag, acc[i], 1);
      set_req(i, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (DEPTH) tick();
   endtask

   initial begin
      req_read = '0; req_write = '0; req_address = '0;
      req_writedata = '0; req_byteenable = '0; clear_start = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (DEPTH) tick();
      set_req(0, 1, 0, 5, 0, 0);
      hold(0, "rd5_acc");
      tick();
      set_req(0, 0, 1, 10, {2{64'h0123_4567_89AB_CDEF}}, 16'h00FF);
      hold(0, "wr10_acc");
      set_req(0, 1, 0, 10, 0, 0);
      hold(0, "rd10_acc");
      tick();
      check("rd10_ram", ram[10], {64'h0, 64'h0123_4567_89AB_CDEF});
      do_reset();
      set_req(0, 1, 0, 10, 0, 0);
      set_req(1, 1, 0, 20, 0, 0);
      repeat (8) tick();
      set_req(0, 0, 0, 0, 0, 0);
      set_req(1, 1, 0, 7, 0, 0);
      tick();
      repeat (3) tick();
      set_req(0, 1, 0, 10, 0, 0);
      tick();
      check("contend_r0", acc, 2'b01);
      set_req(0, 0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0, 0);
      tick();
      set_req(0, 0, 1, 3, {4{32'hCAFE_F00D}}, '1);
      clear_start = 1'b1;
      tick();
      check("cs_acc", acc, 2'b00);
      clear_start = 1'b0;
      check("cs_busy", clear_busy, 1);
      set_req(1, 1, 0, 4, 0, 0);
      hold(0, "wr3_after_clr");
      set_req(1, 0, 0, 0, 0, 0);
      set_req(0, 1, 0, 3, 0, 0);
      hold(0, "rd3_acc");
      set_req(1, 1, 0, 4, 0, 0);
      hold(1, "rd4_acc");
      tick();
      set_req(0, 1, 0, 10, 0, 0);
      tick();
      set_req(0, 0, 0, 0, 0, 0);
      check("pend_before_rst", req_readdatavalid, 2'b01);
      do_reset();
      set_req(1, 1, 0, 10, 0, 0);
      hold(1, "rd_post_rst");
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
